controle_troco: RTL and testbench
=================================

CONTROLE_TROCO -- requirements
Module: controle_troco

Interface
REQ-001 Parameter LARG, default 8: width of credit, price and change values, in units of 5 cents.
REQ-002 Parameter TIMEOUT_ACK, default 255: maximum cycles moeda_req waits for moeda_ack.
REQ-003 Parameter ESTOQUE_INI, default 8: coins per denomination after reset (8-bit counters).
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 inicio  in  1  start-of-sale pulse; sampled only in OCIOSO.
REQ-007 credito  in  LARG  inserted credit; captured when inicio is accepted.
REQ-008 preco  in  LARG  selected product price; captured with credito.
REQ-009 moeda_ack  in  1  coin dispenser acknowledge, one coin ejected.
REQ-010 recarga  in  1  refill pulse, adds one coin of type recarga_tipo.
REQ-011 recarga_tipo  in  2  refill denomination.
REQ-012 ocupado  out  1  high in every state except OCIOSO.
REQ-013 produto_lib  out  1  one-cycle product release pulse.
REQ-014 moeda_req  out  1  coin eject request.
REQ-015 moeda_tipo  out  2  denomination requested: 0=20u (R$1.00), 1=10u, 2=5u, 3=1u.
REQ-016 troco_rest  out  LARG  change still owed.
REQ-017 concluido  out  1  one-cycle pulse, sale finished with full change.
REQ-018 insuficiente  out  1  one-cycle pulse, credito < preco, no release.
REQ-019 erro_troco  out  1  one-cycle pulse, change cannot be completed; troco_rest holds the remainder until the next accepted inicio.

Function
REQ-020 The FSM SHALL have states OCIOSO, VERIFICA, LIBERA, SELECIONA, PEDE, FIM, ERRO; all outputs SHALL be Moore, decoded from registered state and data.
REQ-021 OCIOSO: inicio=1 SHALL capture credito and preco and go to VERIFICA; troco_rest is cleared to 0 on capture.
REQ-022 VERIFICA: credito<preco SHALL pulse insuficiente and return to OCIOSO; otherwise troco_rest SHALL load credito-preco (no borrow possible) and go to LIBERA.
REQ-023 LIBERA: produto_lib SHALL be 1 for exactly this cycle, then SELECIONA; latency from accepted inicio at cycle N to produto_lib is N+2.
REQ-024 SELECIONA: troco_rest=0 SHALL go to FIM; otherwise moeda_tipo SHALL latch the largest denomination with value <= troco_rest and available stock, then go to PEDE; if none qualifies go to ERRO.
REQ-025 PEDE: moeda_req SHALL stay 1 and moeda_tipo stable until moeda_ack=1 is sampled; on ack troco_rest decrements by the coin value, that stock decrements, and the FSM returns to SELECIONA.
REQ-026 moeda_ack outside PEDE SHALL be ignored.
REQ-027 A wait counter SHALL clear on entering PEDE; after TIMEOUT_ACK cycles without ack the FSM SHALL go to ERRO with troco_rest unchanged.
REQ-028 FIM pulses concluido; ERRO pulses erro_troco; both return to OCIOSO next cycle.
REQ-029 inicio while ocupado=1 SHALL be ignored, without queuing.
REQ-030 recarga SHALL increment the selected stock counter, saturating at 255, in any state; recarga and ack-decrement on the same counter in one cycle SHALL leave it unchanged.

Reset
REQ-031 reset SHALL force OCIOSO, all outputs 0, troco_rest 0, wait counter 0, all stock counters ESTOQUE_INI; mid-dispense reset SHALL abandon the sale with no error pulse.

Configuration
REQ-032 With TROCO_ESTOQUE_EN defined, stock counters, recarga handling and the availability check of REQ-024 SHALL be present.
REQ-033 Without TROCO_ESTOQUE_EN, stock SHALL be treated as unlimited, recarga/recarga_tipo ignored, and ERRO reachable only by timeout.

Verification
REQ-034 credito=40, preco=13, immediate acks -> produto_lib at N+2, coins 20,5,1,1 in order, troco_rest 0, concluido once.
REQ-035 credito=10, preco=15 -> insuficiente at N+1, no produto_lib, no moeda_req.
REQ-036 credito=preco=30 -> produto_lib at N+2, no moeda_req, concluido at N+4.
REQ-037 TROCO_ESTOQUE_EN, stock type3=0, change 3 -> produto_lib, then erro_troco with troco_rest=3, no moeda_req.
REQ-038 Change 10, moeda_ack held 0 -> moeda_req high for TIMEOUT_ACK cycles, then erro_troco, troco_rest=10.
REQ-039 Reset asserted during PEDE -> next cycle OCIOSO, moeda_req 0, stocks ESTOQUE_INI; inicio during ocupado ignored.

Source files
------------

// File: rtl/controle_troco.sv
// Change-dispensing controller for a vending machine: checks credit, releases the product and
// ejects change coin by coin. Optional macro TROCO_ESTOQUE_EN enables per-denomination coin stock.
module controle_troco #(
   parameter int LARG        = 8,
   parameter int TIMEOUT_ACK = 255,
   parameter int ESTOQUE_INI = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            inicio,
   input  logic [LARG-1:0] credito,
   input  logic [LARG-1:0] preco,
   input  logic            moeda_ack,
   input  logic            recarga,
   input  logic [1:0]      recarga_tipo,
   output logic            ocupado,
   output logic            produto_lib,
   output logic            moeda_req,
   output logic [1:0]      moeda_tipo,
   output logic [LARG-1:0] troco_rest,
   output logic            concluido,
   output logic            insuficiente,
   output logic            erro_troco
);

   localparam int CW = (TIMEOUT_ACK < 2) ? 1 : $clog2(TIMEOUT_ACK + 1);

   typedef enum logic [2:0] {
      OCIOSO, VERIFICA, LIBERA, SELECIONA, PEDE, FIM, ERRO
   } estado_t;

   estado_t         st;
   logic [LARG-1:0] cred_r, prec_r;
   logic [CW-1:0]   cnt;
   logic [3:0]      disp;
   logic            sel_ok;
   logic [1:0]      sel_tipo;

   // Coin value in 5-cent units, indexed by moeda_tipo encoding.
   function automatic logic [LARG-1:0] valor(input logic [1:0] t);
      case (t)
         2'd0:    valor = LARG'(20);
         2'd1:    valor = LARG'(10);
         2'd2:    valor = LARG'(5);
         default: valor = LARG'(1);
      endcase
   endfunction

`ifdef TROCO_ESTOQUE_EN
   logic [3:0][7:0] estoque;

   for (genvar g = 0; g < 4; g++) begin : g_estoque
      logic inc, dec;
      assign inc     = recarga && (recarga_tipo == 2'(g));
      assign dec     = (st == PEDE) && moeda_ack && (moeda_tipo == 2'(g));
      assign disp[g] = (estoque[g] != 8'd0);

      // Refill and dispense on the same counter in one cycle cancel out.
      always_ff @(posedge clock) begin
         if (reset)
            estoque[g] <= 8'(ESTOQUE_INI);
         else if (inc && !dec && estoque[g] != 8'hFF)
            estoque[g] <= estoque[g] + 8'd1;
         else if (dec && !inc && estoque[g] != 8'd0)
            estoque[g] <= estoque[g] - 8'd1;
      end
   end
`else
   logic unused_recarga;
   assign unused_recarga = ^{recarga, recarga_tipo};
   assign disp           = 4'hF;
`endif

   // Scan small to large so the largest qualifying coin wins.
   always_comb begin
      sel_ok   = 1'b0;
      sel_tipo = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (valor(2'(i)) <= troco_rest && disp[i]) begin
            sel_ok   = 1'b1;
            sel_tipo = 2'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st         <= OCIOSO;
         cred_r     <= '0;
         prec_r     <= '0;
         troco_rest <= '0;
         moeda_tipo <= 2'd0;
         cnt        <= '0;
      end else begin
         case (st)
            OCIOSO: if (inicio) begin
               cred_r     <= credito;
               prec_r     <= preco;
               troco_rest <= '0;
               st         <= VERIFICA;
            end
            VERIFICA: if (cred_r < prec_r)
               st <= OCIOSO;
            else begin
               troco_rest <= cred_r - prec_r;
               st         <= LIBERA;
            end
            LIBERA: st <= SELECIONA;
            SELECIONA: if (troco_rest == '0)
               st <= FIM;
            else if (sel_ok) begin
               moeda_tipo <= sel_tipo;
               cnt        <= '0;
               st         <= PEDE;
            end else
               st <= ERRO;
            PEDE: if (moeda_ack) begin
               troco_rest <= troco_rest - valor(moeda_tipo);
               st         <= SELECIONA;
            end else if (cnt == CW'(TIMEOUT_ACK - 1))
               st <= ERRO;
            else
               cnt <= cnt + 1'b1;
            FIM:     st <= OCIOSO;
            ERRO:    st <= OCIOSO;
            default: st <= OCIOSO;
         endcase
      end
   end

   assign ocupado      = (st != OCIOSO);
   assign produto_lib  = (st == LIBERA);
   assign moeda_req    = (st == PEDE);
   assign concluido    = (st == FIM);
   assign erro_troco   = (st == ERRO);
   assign insuficiente = (st == VERIFICA) && (cred_r < prec_r);

endmodule

// File: tb/tb_controle_troco.sv
// Directed bench for controle_troco: sale timing, coin order, insufficient credit,
// ack timeout, mid-sale reset; stock cases when TROCO_ESTOQUE_EN is defined.
module tb_controle_troco;
   localparam int LARG = 8;
   localparam int TMO  = 6;

   logic            clock = 1'b0, reset = 1'b1, inicio = 1'b0, moeda_ack = 1'b0, recarga = 1'b0;
   logic [1:0]      recarga_tipo = 2'd0;
   logic [LARG-1:0] credito = '0, preco = '0;
   logic            ocupado, produto_lib, moeda_req, concluido, insuficiente, erro_troco;
   logic [1:0]      moeda_tipo;
   logic [LARG-1:0] troco_rest;

   controle_troco #(.LARG(LARG), .TIMEOUT_ACK(TMO), .ESTOQUE_INI(8)) dut (
      .clock(clock), .reset(reset), .inicio(inicio), .credito(credito), .preco(preco),
      .moeda_ack(moeda_ack), .recarga(recarga), .recarga_tipo(recarga_tipo),
      .ocupado(ocupado), .produto_lib(produto_lib), .moeda_req(moeda_req),
      .moeda_tipo(moeda_tipo), .troco_rest(troco_rest), .concluido(concluido),
      .insuficiente(insuficiente), .erro_troco(erro_troco)
   );

   always #5 clock = ~clock;

   int n_chk = 0, n_ok = 0;
   int lib_at, lib_troco, ver_troco, conc_at, conc_n, err_n, ins_n, ins_at, req_n, end_troco;
   int coins[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_ok++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   // One sale from inicio until ocupado drops; k is the cycle offset from acceptance.
   task automatic run_sale(input int cred, input int pr, input logic ack, input logic poke);
      int k;
      logic done;
      lib_at = -1; lib_troco = -1; ver_troco = -1; conc_at = -1; ins_at = -1;
      conc_n = 0; err_n = 0; ins_n = 0; req_n = 0; end_troco = -1; done = 1'b0;
      coins.delete();
      credito = LARG'(cred); preco = LARG'(pr); moeda_ack = ack; inicio = 1'b1;
      tick();
      inicio = 1'b0;
      for (k = 1; k < 60 && !done; k++) begin
         if (!ocupado) done = 1'b1;
         else begin
            if (k == 1) ver_troco = int'(troco_rest);
            if (produto_lib && lib_at < 0) begin lib_at = k; lib_troco = int'(troco_rest); end
            if (moeda_req) begin
               req_n++;
               if (moeda_ack) coins.push_back(int'(moeda_tipo));
            end
            if (concluido) begin conc_n++; conc_at = k; end_troco = int'(troco_rest); end
            if (erro_troco) begin err_n++; end_troco = int'(troco_rest); end
            if (insuficiente) begin ins_n++; ins_at = k; end
            if (poke && k == 3) begin credito = 8'd99; preco = 8'd0; inicio = 1'b1; end
            else inicio = 1'b0;
            tick();
         end
      end
      inicio = 1'b0;
      if (!done) chk("sale_bound", 0, 1);
   endtask

   task automatic chk_coins(input string tag, input int e0, input int e1, input int e2, input int e3, input int n);
      int exp[4];
      exp = '{e0, e1, e2, e3};
      chk({tag, "_ncoins"}, coins.size(), n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_coin%0d", tag, i), (i < coins.size()) ? coins[i] : -1, exp[i]);
   endtask

   initial begin
      int got;
      tick(); tick();
      chk("rst_ocupado", int'(ocupado), 0);
      chk("rst_moeda_req", int'(moeda_req), 0);
      chk("rst_troco", int'(troco_rest), 0);
      chk("rst_pulses", int'({produto_lib, concluido, insuficiente, erro_troco}), 0);
      reset = 1'b0;
      tick();

      // 40 - 13 = 27 -> 20, 5, 1, 1; ack held high also exercises ack outside PEDE
      run_sale(40, 13, 1'b1, 1'b0);
      chk("t1_lib_at", lib_at, 2);
      chk("t1_lib_troco", lib_troco, 27);
      chk_coins("t1", 0, 2, 3, 3, 4);
      chk("t1_req_n", req_n, 4);
      chk("t1_conc_n", conc_n, 1);
      chk("t1_end_troco", end_troco, 0);
      chk("t1_err_n", err_n, 0);

      run_sale(10, 15, 1'b1, 1'b0);
      chk("t2_ins_n", ins_n, 1);
      chk("t2_ins_at", ins_at, 1);
      chk("t2_lib_at", lib_at, -1);
      chk("t2_req_n", req_n, 0);
      chk("t2_troco", int'(troco_rest), 0);

      // change 10 with no ack: timeout; inicio poked while busy must be ignored
      run_sale(20, 10, 1'b0, 1'b1);
      chk("t4_lib_at", lib_at, 2);
      chk("t4_req_n", req_n, TMO);
      chk("t4_err_n", err_n, 1);
      chk("t4_end_troco", end_troco, 10);
      chk("t4_conc_n", conc_n, 0);
      chk("t4_tipo", int'(moeda_tipo), 1);
      tick(); tick();
      chk("t4_hold_troco", int'(troco_rest), 10);
      chk("t4_idle", int'(ocupado), 0);

      run_sale(30, 30, 1'b1, 1'b0);
      chk("t3_ver_troco", ver_troco, 0);
      chk("t3_lib_at", lib_at, 2);
      chk("t3_req_n", req_n, 0);
      chk("t3_conc_at", conc_at, 4);
      chk("t3_conc_n", conc_n, 1);

      // reset while waiting for ack
      credito = 8'd20; preco = 8'd15; moeda_ack = 1'b0; inicio = 1'b1;
      tick();
      inicio = 1'b0;
      got = 0;
      for (int k = 0; k < 10 && got == 0; k++) begin
         tick();
         if (moeda_req) got = 1;
      end
      chk("t5_reached_pede", got, 1);
      reset = 1'b1;
      tick();
      chk("t5_ocupado", int'(ocupado), 0);
      chk("t5_moeda_req", int'(moeda_req), 0);
      chk("t5_erro", int'(erro_troco), 0);
      chk("t5_troco", int'(troco_rest), 0);
      reset = 1'b0;
      tick();
      run_sale(20, 15, 1'b1, 1'b0);
      chk_coins("t5b", 2, 0, 0, 0, 1);
      chk("t5b_conc_n", conc_n, 1);

`ifdef TROCO_ESTOQUE_EN
      // drain the eight 1-unit coins, then change 3 cannot be paid
      run_sale(4, 0, 1'b1, 1'b0);
      chk_coins("s1", 3, 3, 3, 3, 4);
      run_sale(4, 0, 1'b1, 1'b0);
      chk_coins("s2", 3, 3, 3, 3, 4);
      run_sale(3, 0, 1'b1, 1'b0);
      chk("s3_lib_at", lib_at, 2);
      chk("s3_req_n", req_n, 0);
      chk("s3_err_n", err_n, 1);
      chk("s3_end_troco", end_troco, 3);
      recarga = 1'b1; recarga_tipo = 2'd3;
      tick();
      recarga = 1'b0;
      run_sale(1, 0, 1'b1, 1'b0);
      chk_coins("s4", 3, 0, 0, 0, 1);
      chk("s4_conc_n", conc_n, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      run_sale(3, 0, 1'b1, 1'b0);
      chk_coins("s5", 3, 3, 3, 0, 3);
      chk("s5_conc_n", conc_n, 1);
`endif

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule
